fpu_cmp_fcc_stage: RTL and testbench
====================================

FPU_CMP_FCC_STAGE -- requirements
Module: fpu_cmp_fcc_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port in_vld, input, 1, compare request valid.
REQ-004 SHALL have port in_rdy, output, 1, stage can accept a request this cycle.
REQ-005 SHALL have port din2_neq_din1, input, 1, reduced |rs2| != |rs1| from the 3-to-1 magnitude reducer.
REQ-006 SHALL have port din2_gt_din1, input, 1, reduced |rs2| > |rs1|.
REQ-007 SHALL have ports rs1_sign and rs2_sign, input, 1 each, operand sign bits.
REQ-008 SHALL have ports rs1_zero and rs2_zero, input, 1 each, operand is +/-0.
REQ-009 SHALL have ports rs1_nan, rs2_nan, rs1_snan and rs2_snan, input, 1 each, NaN and signalling-NaN flags.
REQ-010 SHALL have port cmpe, input, 1, the request is FCMPE (signal on any NaN).
REQ-011 SHALL have port fcc_id, input, 2, target fcc field (fcc0..fcc3), carried unchanged.
REQ-012 SHALL have port flush, input, 1, kill all in-flight requests.
REQ-013 SHALL have ports out_vld, output, 1, and out_rdy, input, 1, result handshake.
REQ-014 SHALL have port out_fcc, output, 2: 0 = equal, 1 = rs1<rs2, 2 = rs1>rs2, 3 = unordered.
REQ-015 SHALL have port out_nv, output, 1, invalid-operation exception.
REQ-016 SHALL have port out_fcc_id, output, 2, the carried target field.

Function
REQ-017 SHALL be a 2-stage pipeline: S1 registers the inputs, S2 registers the computed fcc, nv and id.
REQ-018 SHALL transfer a request on a cycle with in_vld && in_rdy and present out_vld exactly 2 edges later when no stall occurs.
REQ-019 SHALL drive in_rdy = !s1_vld || s1_adv, where s1_adv = !s2_vld || out_rdy.
REQ-020 SHALL complete a result transfer on out_vld && out_rdy, and SHALL hold out_fcc, out_nv and out_fcc_id stable while out_vld && !out_rdy.
REQ-021 SHALL sustain full throughput (one request per cycle) while out_rdy is held at 1.
REQ-022 SHALL keep S1 contents when S1 is valid and cannot advance; no request is lost or duplicated.
REQ-023 SHALL set fcc to 3 when rs1_nan || rs2_nan.
REQ-024 SHALL set fcc to 0 when rs1_zero && rs2_zero, regardless of signs.
REQ-025 SHALL, for differing signs without the double-zero case, set fcc to 1 if rs1_sign else 2.
REQ-026 SHALL, for both positive, set fcc to 0 if !neq, 1 if gt, else 2.
REQ-027 SHALL, for both negative, set fcc to 0 if !neq, 2 if gt, else 1.
REQ-028 SHALL assert nv when (rs1_snan || rs2_snan) || (cmpe && (rs1_nan || rs2_nan)).
REQ-029 SHALL clear s1_vld and s2_vld at the next edge when flush is 1, SHALL accept no request that cycle, and SHALL hold in_rdy at 0 during flush.
REQ-030 SHALL let flush override a simultaneous output handshake; the S2 entry is dropped.

Reset
REQ-031 SHALL, with rst asserted, immediately clear s1_vld and s2_vld to 0, so out_vld = 0 and in_rdy = 1 after release.
REQ-032 SHALL reset out_fcc, out_nv and out_fcc_id to 0.
REQ-033 SHALL discard any in-flight request when rst is asserted mid-operation and produce no spurious out_vld after release.

Structure
REQ-034 SHALL take fcc encodings (FCC_EQ=0, FCC_LT=1, FCC_GT=2, FCC_UN=3) from the shared FPU package.
REQ-035 SHALL place the combinational fcc/nv decode in one sub-module, fpu_cmp_fcc_dec, instantiated between S1 and S2.

Verification
REQ-036 SHALL cover: +2.0 vs +3.0 (signs 0/0, neq=1, gt=1), out_rdy=1 -> out_fcc=1, nv=0, two cycles after accept.
REQ-037 SHALL cover: -2.0 vs -3.0 (signs 1/1, neq=1, gt=1) -> fcc=2; +0 vs -0 -> fcc=0.
REQ-038 SHALL cover: rs2 QNaN with cmpe=0 -> fcc=3, nv=0; the same with cmpe=1 -> fcc=3, nv=1; rs1 SNaN with cmpe=0 -> nv=1.
REQ-039 SHALL cover: 4 back-to-back requests with out_rdy low for 3 cycles -> in_rdy drops after 2 accepts, and all 4 results emerge in order with held values.
REQ-040 SHALL cover: flush with both stages valid and out_rdy=1 -> out_vld=0 the next cycle and no result delivered.
REQ-041 SHALL cover: rst pulsed with 2 requests in flight -> out_vld=0 and in_rdy=1 after release, and no stale result appears.

Source files
------------

// File: rtl/fpu_cmp_fcc_stage_pkg.sv
// Shared FPU compare definitions: fcc encodings and the request/result bundles
// carried through the compare pipeline.
package fpu_cmp_fcc_stage_pkg;

  typedef enum logic [1:0] {
    FCC_EQ = 2'd0,
    FCC_LT = 2'd1,
    FCC_GT = 2'd2,
    FCC_UN = 2'd3
  } fcc_e;

  // neq/gt are the reduced |rs2| != |rs1| and |rs2| > |rs1| from the magnitude reducer
  typedef struct packed {
    logic       neq;
    logic       gt;
    logic       rs1_sign;
    logic       rs2_sign;
    logic       rs1_zero;
    logic       rs2_zero;
    logic       rs1_nan;
    logic       rs2_nan;
    logic       rs1_snan;
    logic       rs2_snan;
    logic       cmpe;
    logic [1:0] fcc_id;
  } cmp_req_t;

  typedef struct packed {
    fcc_e       fcc;
    logic       nv;
    logic [1:0] fcc_id;
  } cmp_res_t;

endpackage

// File: rtl/fpu_cmp_fcc_dec.sv
// Combinational fcc/nv decode of a registered compare request.
// Sits between the S1 and S2 registers of the compare stage.
module fpu_cmp_fcc_dec
  import fpu_cmp_fcc_stage_pkg::*;
(
  input  cmp_req_t req,
  output cmp_res_t res
);

  logic any_nan;

  assign any_nan = req.rs1_nan | req.rs2_nan;

  always_comb begin
    res        = '0;
    res.fcc_id = req.fcc_id;
    res.nv     = req.rs1_snan | req.rs2_snan | (req.cmpe & any_nan);

    if (any_nan) begin
      res.fcc = FCC_UN;
    end else if (req.rs1_zero && req.rs2_zero) begin
      res.fcc = FCC_EQ;
    end else if (req.rs1_sign != req.rs2_sign) begin
      res.fcc = req.rs1_sign ? FCC_LT : FCC_GT;
    end else if (!req.neq) begin
      res.fcc = FCC_EQ;
    end else if (!req.rs1_sign) begin
      res.fcc = req.gt ? FCC_LT : FCC_GT;
    end else begin
      // both negative: larger magnitude means smaller value
      res.fcc = req.gt ? FCC_GT : FCC_LT;
    end
  end

endmodule

// File: rtl/fpu_cmp_fcc_stage.sv
// Two-stage FP compare pipeline producing fcc and invalid flag with valid/ready
// handshakes on both sides; flush kills every in-flight request.
module fpu_cmp_fcc_stage
  import fpu_cmp_fcc_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_vld,
  output logic       in_rdy,
  input  logic       din2_neq_din1,
  input  logic       din2_gt_din1,
  input  logic       rs1_sign,
  input  logic       rs2_sign,
  input  logic       rs1_zero,
  input  logic       rs2_zero,
  input  logic       rs1_nan,
  input  logic       rs2_nan,
  input  logic       rs1_snan,
  input  logic       rs2_snan,
  input  logic       cmpe,
  input  logic [1:0] fcc_id,
  input  logic       flush,
  output logic       out_vld,
  input  logic       out_rdy,
  output logic [1:0] out_fcc,
  output logic       out_nv,
  output logic [1:0] out_fcc_id
);

  cmp_req_t in_req;
  cmp_req_t s1_req;
  cmp_res_t dec_res;
  cmp_res_t s2_res;
  logic     s1_vld;
  logic     s2_vld;
  logic     s1_adv;
  logic     s1_load;

  always_comb begin
    in_req          = '0;
    in_req.neq      = din2_neq_din1;
    in_req.gt       = din2_gt_din1;
    in_req.rs1_sign = rs1_sign;
    in_req.rs2_sign = rs2_sign;
    in_req.rs1_zero = rs1_zero;
    in_req.rs2_zero = rs2_zero;
    in_req.rs1_nan  = rs1_nan;
    in_req.rs2_nan  = rs2_nan;
    in_req.rs1_snan = rs1_snan;
    in_req.rs2_snan = rs2_snan;
    in_req.cmpe     = cmpe;
    in_req.fcc_id   = fcc_id;
  end

  assign s1_adv  = !s2_vld || out_rdy;
  assign s1_load = !s1_vld || s1_adv;
  // flush forces in_rdy low so nothing is accepted in the cycle being killed
  assign in_rdy  = s1_load && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_req <= '0;
    end else if (flush) begin
      s1_vld <= 1'b0;
    end else if (s1_load) begin
      s1_vld <= in_vld;
      if (in_vld) begin
        s1_req <= in_req;
      end
    end
  end

  fpu_cmp_fcc_dec u_dec (
    .req (s1_req),
    .res (dec_res)
  );

  // S2 only reloads when empty or draining, so outputs hold under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld <= 1'b0;
      s2_res <= '0;
    end else if (flush) begin
      s2_vld <= 1'b0;
    end else if (s1_adv) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_res <= dec_res;
      end
    end
  end

  assign out_vld    = s2_vld;
  assign out_fcc    = s2_res.fcc;
  assign out_nv     = s2_res.nv;
  assign out_fcc_id = s2_res.fcc_id;

endmodule

// File: tb/tb_fpu_cmp_fcc_stage.sv
// Directed bench for the FP compare fcc stage: decode cases, backpressure,
// throughput, flush and mid-operation reset.
module tb_fpu_cmp_fcc_stage;
  import fpu_cmp_fcc_stage_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_vld;
  logic       in_rdy;
  logic       flush;
  logic       out_vld;
  logic       out_rdy;
  logic [1:0] out_fcc;
  logic       out_nv;
  logic [1:0] out_fcc_id;
  cmp_req_t   req;

  int checks   = 0;
  int failures = 0;

  cmp_req_t   vec_req [4];
  logic [4:0] vec_exp [4];  // {fcc, nv, fcc_id}

  always #5 clk = ~clk;

  fpu_cmp_fcc_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_vld        (in_vld),
    .in_rdy        (in_rdy),
    .din2_neq_din1 (req.neq),
    .din2_gt_din1  (req.gt),
    .rs1_sign      (req.rs1_sign),
    .rs2_sign      (req.rs2_sign),
    .rs1_zero      (req.rs1_zero),
    .rs2_zero      (req.rs2_zero),
    .rs1_nan       (req.rs1_nan),
    .rs2_nan       (req.rs2_nan),
    .rs1_snan      (req.rs1_snan),
    .rs2_snan      (req.rs2_snan),
    .cmpe          (req.cmpe),
    .fcc_id        (req.fcc_id),
    .flush         (flush),
    .out_vld       (out_vld),
    .out_rdy       (out_rdy),
    .out_fcc       (out_fcc),
    .out_nv        (out_nv),
    .out_fcc_id    (out_fcc_id)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic cmp_req_t mk(input logic neq, gt, s1, s2, z1, z2, n1, n2,
                                  sn1, sn2, ce, input logic [1:0] id);
    cmp_req_t r;
    r = '{neq, gt, s1, s2, z1, z2, n1, n2, sn1, sn2, ce, id};
    return r;
  endfunction

  // One isolated request with out_rdy high: result must appear 2 edges after accept.
  task automatic single(input string tag, input cmp_req_t r, input logic [1:0] efcc, input logic env);
    @(negedge clk);
    req = r; in_vld = 1'b1; out_rdy = 1'b1;
    #1 chk({tag, "_in_rdy"}, in_rdy, 1);
    @(negedge clk);
    in_vld = 1'b0;
    chk({tag, "_vld_early"}, out_vld, 0);
    @(negedge clk);
    chk({tag, "_vld"}, out_vld, 1);
    chk({tag, "_fcc"}, out_fcc, efcc);
    chk({tag, "_nv"}, out_nv, env);
    chk({tag, "_id"}, out_fcc_id, r.fcc_id);
  endtask

  // Stream vec_req[0..3] with out_rdy low for the first 'stall' cycles.
  task automatic run_stream(input string tag, input int stall);
    int sent = 0;
    int rcv  = 0;
    for (int cyc = 0; cyc < 40 && rcv < 4; cyc++) begin
      @(negedge clk);
      out_rdy = (cyc >= stall);
      in_vld  = (sent < 4);
      if (sent < 4) req = vec_req[sent];
      #1;
      if (stall == 3 && cyc == 2) begin
        chk({tag, "_in_rdy_low"}, in_rdy, 0);
        chk({tag, "_accepts"}, sent, 2);
      end
      if (stall == 0 && in_vld) chk({tag, "_in_rdy_hi"}, in_rdy, 1);
      if (out_vld) begin
        chk({tag, "_res"}, {out_fcc, out_nv, out_fcc_id}, vec_exp[rcv]);
        if (out_rdy) rcv++;
      end
      if (in_vld && in_rdy) sent++;
    end
    @(negedge clk);
    in_vld = 1'b0;
    chk({tag, "_count"}, rcv, 4);
    chk({tag, "_drained"}, out_vld, 0);
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; flush = 1'b0; out_rdy = 1'b0; req = '0;

    //             neq gt s1 s2 z1 z2 n1 n2 sn1 sn2 ce id
    vec_req[0] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0); vec_exp[0] = 5'b01_0_00;
    vec_req[1] = mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'd1); vec_exp[1] = 5'b10_0_01;
    vec_req[2] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2'd2); vec_exp[2] = 5'b11_1_10;
    vec_req[3] = mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 2'd3); vec_exp[3] = 5'b00_0_11;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_vld", out_vld, 0);
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_fcc", out_fcc, 0);
    chk("rst_nv", out_nv, 0);
    chk("rst_id", out_fcc_id, 0);

    single("pos_lt",     mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1), 2'd1, 1'b0);
    single("neg_gt",     mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'd2), 2'd2, 1'b0);
    single("zero_eq",    mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 2'd3), 2'd0, 1'b0);
    single("qnan_fcmp",  mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0), 2'd3, 1'b0);
    single("qnan_fcmpe", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2'd1), 2'd3, 1'b1);
    single("snan_fcmp",  mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2'd2), 2'd3, 1'b1);
    single("pos_eq",     mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3), 2'd0, 1'b0);
    single("sign_lt",    mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0), 2'd1, 1'b0);
    single("neg_lt",     mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'd1), 2'd1, 1'b0);
    single("pos_gt",     mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2), 2'd2, 1'b0);

    run_stream("bp", 3);
    run_stream("tp", 0);

    // flush with both stages full and a simultaneous output handshake
    @(negedge clk); out_rdy = 1'b0; req = vec_req[0]; in_vld = 1'b1;
    @(negedge clk); req = vec_req[1];
    @(negedge clk); req = vec_req[2]; flush = 1'b1; out_rdy = 1'b1;
    #1;
    chk("fl_out_vld_pre", out_vld, 1);
    chk("fl_in_rdy", in_rdy, 0);
    @(negedge clk); flush = 1'b0; in_vld = 1'b0;
    chk("fl_out_vld", out_vld, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fl_no_result", out_vld, 0);
    end

    // asynchronous reset with two requests in flight
    @(negedge clk); out_rdy = 1'b0; req = vec_req[0]; in_vld = 1'b1;
    @(negedge clk); req = vec_req[1];
    @(negedge clk); in_vld = 1'b0;
    chk("rs_out_vld_pre", out_vld, 1);
    #2 rst = 1'b1;
    #1;
    chk("rs_out_vld_async", out_vld, 0);
    chk("rs_fcc_async", out_fcc, 0);
    chk("rs_id_async", out_fcc_id, 0);
    @(negedge clk); rst = 1'b0; out_rdy = 1'b1;
    #1 chk("rs_in_rdy", in_rdy, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rs_no_stale", out_vld, 0);
    end

    single("post_rst", mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'd2), 2'd2, 1'b0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
